vip_featuremap_channel_packer: RTL and testbench

- Producer side of the 8-channel parallel feature-map write interface used by the conv2d layer blocks.
- Drains a serial 32-bit word stream from an upstream normal-mode FIFO (rdreq/empty, q valid one cycle after rdreq). Stream is ordered channel 0..7 per pixel.
- Gathers 8 consecutive words into one pixel vector, then presents all 8 on parallel data buses with a single wrreq, honouring the downstream full flag.
- Counts pixels per frame and pulses frame_done at frame end.

---
 rtl/vip_featuremap_channel_packer.sv | 158 +++++++++++++++
 tb/tb_vip_featuremap_channel_packer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vip_featuremap_channel_packer.sv
`default_nettype none
// ============================================================================
// Module   : vip_featuremap_channel_packer
// Purpose  : Producer side of the 8-channel parallel feature-map write path.
//            Drains a serial word stream (channel 0..7 per pixel) from an
//            upstream normal-mode FIFO, gathers 8 words into one pixel and
//            writes the pixel to the downstream 8-bus interface with a single
//            wrreq while honouring out_full. Counts pixels per frame and
//            pulses frame_done on the write of the last pixel of a frame.
// Ports    : clock        - rising-edge clock
//            reset        - asynchronous active-low reset
//            in_data      - upstream FIFO q (valid the cycle after in_rdreq)
//            in_empty     - upstream FIFO empty
//            in_rdreq     - upstream FIFO read request
//            out_data0..7 - channel 0..7 word of the current pixel
//            out_wrreq    - downstream write strobe (one pixel per cycle)
//            out_full     - downstream full, blocks writes
//            frame_done   - one-cycle pulse with the last write of a frame
//            frame_cnt    - completed-frame count
// Options  : VIP_PACKER_FRAME_CNT_EN - builds the 16-bit wrapping frame_cnt
//            register; when undefined frame_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module vip_featuremap_channel_packer #(
  parameter int DWIDTH     = 32,
  parameter int NUM_PIXELS = 12544
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_empty,
  output logic              in_rdreq,
  output logic [DWIDTH-1:0] out_data0,
  output logic [DWIDTH-1:0] out_data1,
  output logic [DWIDTH-1:0] out_data2,
  output logic [DWIDTH-1:0] out_data3,
  output logic [DWIDTH-1:0] out_data4,
  output logic [DWIDTH-1:0] out_data5,
  output logic [DWIDTH-1:0] out_data6,
  output logic [DWIDTH-1:0] out_data7,
  output logic              out_wrreq,
  input  logic              out_full,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  localparam int c_pix_w = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [c_pix_w-1:0] c_last_pix = c_pix_w'(NUM_PIXELS - 1);
  localparam logic [c_pix_w-1:0] c_pix_one  = c_pix_w'(1);

  localparam logic [0:0] c_st_fill = 1'b0;
  localparam logic [0:0] c_st_push = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [3:0]        r_rd_idx;      // reads issued for the current pixel (0..8)
  logic [2:0]        r_cap_idx;     // next channel slot to be captured
  logic              r_rd_pending;  // q of the previous cycle's read is valid now
  logic [c_pix_w-1:0] r_pix_cnt;
  logic [DWIDTH-1:0] r_data [8];
  logic              w_cap_last;
  logic              w_pix_last;

  // The 8th capture completes the pixel; reads never outrun captures by more
  // than one, so this is also the last outstanding read.
  assign w_cap_last = (r_state == c_st_fill) && r_rd_pending && (r_cap_idx == 3'd7);
  assign w_pix_last = (r_pix_cnt == c_last_pix);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_fill;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_fill: if (w_cap_last) w_state_nxt = c_st_push;
      c_st_push: if (!out_full)  w_state_nxt = c_st_fill;
      default:   w_state_nxt = c_st_fill;
    endcase
  end

  // Output logic
  always_comb begin
    in_rdreq   = 1'b0;
    out_wrreq  = 1'b0;
    frame_done = 1'b0;
    case (r_state)
      c_st_fill: in_rdreq  = !in_empty && !r_rd_idx[3];
      c_st_push: begin
        out_wrreq  = !out_full;
        frame_done = !out_full && w_pix_last;
      end
      default: ;
    endcase
  end

  // Datapath: read/capture indices, pixel buffer, pixel counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_idx     <= 4'd0;
      r_cap_idx    <= 3'd0;
      r_rd_pending <= 1'b0;
      r_pix_cnt    <= '0;
      for (int i = 0; i < 8; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_rd_pending <= in_rdreq;
      if (in_rdreq) begin
        r_rd_idx <= r_rd_idx + 4'd1;
      end
      if (r_rd_pending) begin
        r_data[r_cap_idx] <= in_data;
        r_cap_idx         <= r_cap_idx + 3'd1;
      end
      if (w_cap_last) begin
        r_rd_idx  <= 4'd0;
        r_cap_idx <= 3'd0;
      end
      if (out_wrreq) begin
        r_pix_cnt <= w_pix_last ? '0 : r_pix_cnt + c_pix_one;
      end
    end
  end

  assign out_data0 = r_data[0];
  assign out_data1 = r_data[1];
  assign out_data2 = r_data[2];
  assign out_data3 = r_data[3];
  assign out_data4 = r_data[4];
  assign out_data5 = r_data[5];
  assign out_data6 = r_data[6];
  assign out_data7 = r_data[7];

`ifdef VIP_PACKER_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= 16'd0;
    end else if (frame_done) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vip_featuremap_channel_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vip_featuremap_channel_packer
// Purpose  : Self-checking bench for vip_featuremap_channel_packer with a
//            queue-based upstream FIFO model and a word-stream reference model
//            (pixel k = words 8k..8k+7 since reset, frame end every NP writes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vip_featuremap_channel_packer;

  localparam int DW = 32;
  localparam int NP = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_empty;
  logic          in_rdreq;
  logic [DW-1:0] od0, od1, od2, od3, od4, od5, od6, od7;
  logic          out_wrreq;
  logic          out_full;
  logic          frame_done;
  logic [15:0]   frame_cnt;

  vip_featuremap_channel_packer #(.DWIDTH(DW), .NUM_PIXELS(NP)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_empty(in_empty),
    .in_rdreq(in_rdreq),
    .out_data0(od0), .out_data1(od1), .out_data2(od2), .out_data3(od3),
    .out_data4(od4), .out_data5(od5), .out_data6(od6), .out_data7(od7),
    .out_wrreq(out_wrreq), .out_full(out_full), .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0][31:0] d;
    logic             fd;
    logic [15:0]      fc;
    logic [31:0]      cyc;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] fifo[$];
  logic [31:0] exp_words[$];
  wr_t         mon_w;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_cnt = 0, first_rd = -1, last_rd = -1, viol = 0, stray = 0;
  bit mon_rd = 1'b0;
  int gap_mode = 0;
  bit gap_tog = 1'b0;
  bit full_mode = 1'b0;
  bit full_force = 1'b0;

  // Upstream FIFO model and input drivers (updated just after the edge)
  always @(posedge clock) begin
    if (mon_rd && fifo.size() > 0) in_data <= fifo.pop_front();
    #1;
    gap_tog  = ~gap_tog;
    in_empty = (fifo.size() == 0) || (gap_mode == 1 && gap_tog) ||
               (gap_mode == 2 && ($urandom % 4 == 0));
    out_full = full_mode ? ($urandom % 3 == 0) : full_force;
  end

  // Monitor, sampled mid-cycle
  always @(negedge clock) begin
    cyc++;
    mon_rd = in_rdreq;
    if (in_rdreq) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      if (in_empty) viol++;
    end
    if (frame_done && !out_wrreq) stray++;
    if (out_wrreq) begin
      mon_w.d   = {od7, od6, od5, od4, od3, od2, od1, od0};
      mon_w.fd  = frame_done;
      mon_w.fc  = frame_cnt;
      mon_w.cyc = cyc;
      wr_q.push_back(mon_w);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_w(int k, int c);
    return exp_words[8*k + c];
  endfunction

  function automatic logic [7:0][31:0] exp_pix(int k);
    logic [7:0][31:0] p;
    for (int c = 0; c < 8; c++) p[c] = exp_w(k, c);
    return p;
  endfunction

  function automatic logic exp_fd(int k);
    return ((k + 1) % NP) == 0;
  endfunction

  // frame_cnt seen alongside write k counts frames finished before it
  function automatic logic [15:0] exp_fc(int writes_before);
`ifdef VIP_PACKER_FRAME_CNT_EN
    return 16'(writes_before / NP);
`else
    return 16'(writes_before * 0);
`endif
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo.push_back(w);
    exp_words.push_back(w);
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && wr_q.size() < n; i++) tick();
  endtask

  task automatic do_reset();
    tick();
    reset      = 1'b0;
    gap_mode   = 0;
    full_mode  = 1'b0;
    full_force = 1'b0;
    fifo.delete();
    exp_words.delete();
    repeat (2) tick();
    wr_q.delete();
    rd_cnt = 0; first_rd = -1; last_rd = -1; viol = 0; stray = 0;
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0][31:0] d;
    reset = 1'b0; in_empty = 1'b1; out_full = 1'b0; in_data = '0;
    repeat (3) tick();
    d = {od7, od6, od5, od4, od3, od2, od1, od0};
    checks++; if (in_rdreq !== 1'b0)   begin errors++; $display("FAIL reset_rdreq got %b want 0", in_rdreq); end
    checks++; if (out_wrreq !== 1'b0)  begin errors++; $display("FAIL reset_wrreq got %b want 0", out_wrreq); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    checks++; if (d !== '0)            begin errors++; $display("FAIL reset_data got %h want 0", d); end
    reset = 1'b1;
    repeat (4) tick();
    checks++; if (rd_cnt !== 0 || wr_q.size() !== 0) begin
      errors++; $display("FAIL reset_idle reads=%0d writes=%0d want 0/0", rd_cnt, wr_q.size());
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 8; i++) push_word(32'h10 + i);
    wait_writes(1, 60);
    repeat (5) tick();
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL basic_count got %0d want 1", wr_q.size()); end
    if (wr_q.size() > 0) begin
      for (int c = 0; c < 8; c++) begin
        checks++; if (wr_q[0].d[c] !== exp_w(0, c)) begin
          errors++; $display("FAIL basic_data ch%0d got %h want %h", c, wr_q[0].d[c], exp_w(0, c));
        end
      end
      checks++; if (wr_q[0].cyc - first_rd !== 9) begin
        errors++; $display("FAIL basic_latency got %0d want 9", wr_q[0].cyc - first_rd);
      end
      checks++; if (wr_q[0].fd !== 1'b0) begin errors++; $display("FAIL basic_frame_done got 1 want 0"); end
    end
    checks++; if (rd_cnt !== 8 || last_rd - first_rd !== 7) begin
      errors++; $display("FAIL basic_reads got %0d span %0d want 8 span 7", rd_cnt, last_rd - first_rd);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    gap_mode = 1;
    for (int i = 0; i < 8; i++) push_word(32'hA0 + i);
    wait_writes(1, 80);
    repeat (5) tick();
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL gaps_count got %0d want 1", wr_q.size()); end
    if (wr_q.size() > 0) begin
      checks++; if (wr_q[0].d !== exp_pix(0)) begin
        errors++; $display("FAIL gaps_data got %h want %h", wr_q[0].d, exp_pix(0));
      end
    end
    checks++; if (viol !== 0)   begin errors++; $display("FAIL gaps_read_when_empty got %0d want 0", viol); end
    checks++; if (rd_cnt !== 8) begin errors++; $display("FAIL gaps_reads got %0d want 8", rd_cnt); end
  endtask

  task automatic test_backpressure();
    logic [7:0][31:0] d;
    do_reset();
    full_force = 1'b1;
    for (int i = 0; i < 16; i++) push_word($urandom);
    repeat (14) tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      d = {od7, od6, od5, od4, od3, od2, od1, od0};
      checks++; if (out_wrreq !== 1'b0 || in_rdreq !== 1'b0 || d !== exp_pix(0)) begin
        errors++; $display("FAIL bp_stall cyc%0d wrreq=%b rdreq=%b data=%h want 0/0/%h", i, out_wrreq, in_rdreq, d, exp_pix(0));
      end
    end
    checks++; if (wr_q.size() !== 0 || rd_cnt !== 8) begin
      errors++; $display("FAIL bp_hold writes=%0d reads=%0d want 0/8", wr_q.size(), rd_cnt);
    end
    full_force = 1'b0;
    tick();
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL bp_release got %0d writes want 1", wr_q.size()); end
    wait_writes(2, 60);
    checks++; if (wr_q.size() !== 2) begin errors++; $display("FAIL bp_second_count got %0d want 2", wr_q.size()); end
    for (int k = 0; k < wr_q.size(); k++) begin
      checks++; if (wr_q[k].d !== exp_pix(k)) begin
        errors++; $display("FAIL bp_data pix%0d got %h want %h", k, wr_q[k].d, exp_pix(k));
      end
    end
  endtask

  task automatic test_frame();
    do_reset();
    for (int i = 0; i < 32; i++) push_word(32'(i));
    wait_writes(4, 200);
    checks++; if (wr_q.size() !== 4) begin errors++; $display("FAIL frame_count got %0d want 4", wr_q.size()); end
    for (int i = 0; i < 8; i++) push_word($urandom);
    wait_writes(5, 100);
    repeat (3) tick();
    checks++; if (wr_q.size() !== 5) begin errors++; $display("FAIL frame_extra_count got %0d want 5", wr_q.size()); end
    for (int k = 0; k < wr_q.size(); k++) begin
      checks++; if (wr_q[k].d !== exp_pix(k) || wr_q[k].fd !== exp_fd(k) || wr_q[k].fc !== exp_fc(k)) begin
        errors++; $display("FAIL frame_pix%0d got d=%h fd=%b fc=%0d want d=%h fd=%b fc=%0d",
                           k, wr_q[k].d, wr_q[k].fd, wr_q[k].fc, exp_pix(k), exp_fd(k), exp_fc(k));
      end
    end
    checks++; if (frame_cnt !== exp_fc(5)) begin
      errors++; $display("FAIL frame_cnt_final got %0d want %0d", frame_cnt, exp_fc(5));
    end
  endtask

  task automatic test_reset_midfill();
    logic [7:0][31:0] d;
    do_reset();
    for (int i = 0; i < 5; i++) push_word(32'hE0 + i);
    for (int i = 0; i < 40 && rd_cnt < 5; i++) tick();
    tick();
    checks++; if (rd_cnt !== 5 || wr_q.size() !== 0) begin
      errors++; $display("FAIL midfill_pre reads=%0d writes=%0d want 5/0", rd_cnt, wr_q.size());
    end
    do_reset();
    d = {od7, od6, od5, od4, od3, od2, od1, od0};
    checks++; if (d !== '0) begin errors++; $display("FAIL midfill_cleared got %h want 0", d); end
    for (int i = 0; i < 8; i++) push_word(32'h50 + i);
    wait_writes(1, 60);
    repeat (5) tick();
    checks++; if (wr_q.size() !== 1) begin errors++; $display("FAIL midfill_count got %0d want 1", wr_q.size()); end
    if (wr_q.size() > 0) begin
      checks++; if (wr_q[0].d !== exp_pix(0)) begin
        errors++; $display("FAIL midfill_data got %h want %h", wr_q[0].d, exp_pix(0));
      end
    end
  endtask

  task automatic test_random();
    int npix;
    do_reset();
    gap_mode  = 2;
    full_mode = 1'b1;
    npix = 6 + int'($urandom % 6);
    for (int i = 0; i < 8 * npix; i++) push_word($urandom);
    wait_writes(npix, 4000);
    repeat (20) tick();
    checks++; if (wr_q.size() !== npix) begin errors++; $display("FAIL rand_count got %0d want %0d", wr_q.size(), npix); end
    for (int k = 0; k < wr_q.size(); k++) begin
      checks++; if (wr_q[k].d !== exp_pix(k) || wr_q[k].fd !== exp_fd(k) || wr_q[k].fc !== exp_fc(k)) begin
        errors++; $display("FAIL rand_pix%0d got d=%h fd=%b fc=%0d want d=%h fd=%b fc=%0d",
                           k, wr_q[k].d, wr_q[k].fd, wr_q[k].fc, exp_pix(k), exp_fd(k), exp_fc(k));
      end
    end
    checks++; if (viol !== 0)  begin errors++; $display("FAIL rand_read_when_empty got %0d want 0", viol); end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rand_stray_frame_done got %0d want 0", stray); end
    checks++; if (frame_cnt !== exp_fc(npix)) begin
      errors++; $display("FAIL rand_frame_cnt got %0d want %0d", frame_cnt, exp_fc(npix));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_frame();
    test_reset_midfill();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
